// File: rtl/demux_scan_if.sv
// demux_scan_if: handshake/data bundle between the scan block and its
// environment.
//   start, abort  : capture request / cancel (environment -> block)
//   din           : serial bit from the upstream 4:1 mux
//   word_ack      : consumer accepts Y
//   sel           : upstream mux select (block -> environment)
//   Y, word_valid : captured word and its valid flag
//   busy          : capture in progress
interface demux_scan_if;
  logic       start;
  logic       abort;
  logic       din;
  logic       word_ack;
  logic [1:0] sel;
  logic [3:0] Y;
  logic       word_valid;
  logic       busy;

  modport slave (
    input  start, abort, din, word_ack,
    output sel, Y, word_valid, busy
  );

  modport master (
    output start, abort, din, word_ack,
    input  sel, Y, word_valid, busy
  );
endinterface

// File: rtl/demux_scan.sv
// demux_scan: walks the select of an upstream 4:1 mux through slots 0..3,
// holding each slot for SLOT_CYCLES clocks, samples din on the last cycle of
// each slot into a shadow register, and publishes the full word on Y with a
// valid/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_scan_if.slave (start/abort/din/word_ack in,
//                sel/Y/word_valid/busy out)
module demux_scan #(
  parameter int SLOT_CYCLES = 4  // 1..255
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_scan_if.slave  bus
);

  localparam logic [7:0] CYC_LAST = 8'(SLOT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] y_q, y_d;
  logic       wv_q, wv_d;

  // Shadow word with the current din merged into the active slot; on the
  // final sampling edge this is the complete word, so Y never sees a
  // partially filled value.
  logic [3:0] shadow_smp;

  always_comb begin
    shadow_smp        = shadow_q;
    shadow_smp[sel_q] = bus.din;
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    wv_d     = wv_q;

    unique case (state_q)
      IDLE: begin
        // abort outranks start here
        if (bus.start && !bus.abort) begin
          state_d  = CAPTURE;
          cyc_d    = 8'd0;
          sel_d    = 2'd0;
          shadow_d = 4'd0;
        end
      end

      CAPTURE: begin
        if (bus.abort) begin
          // cancel wins even on the final sampling edge; Y/word_valid kept
          state_d  = IDLE;
          cyc_d    = 8'd0;
          sel_d    = 2'd0;
          shadow_d = 4'd0;
        end else if (cyc_q == CYC_LAST) begin
          cyc_d    = 8'd0;
          shadow_d = shadow_smp;
          if (sel_q == 2'd3) begin
            state_d  = HOLD;
            sel_d    = 2'd0;
            y_d      = shadow_smp;
            wv_d     = 1'b1;
            shadow_d = 4'd0;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end

      HOLD: begin
        // start alone is dropped; only start together with ack chains
        // straight into the next capture
        if (bus.word_ack) begin
          wv_d = 1'b0;
          if (bus.start) begin
            state_d  = CAPTURE;
            cyc_d    = 8'd0;
            sel_d    = 2'd0;
            shadow_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        cyc_d    = 8'd0;
        sel_d    = 2'd0;
        shadow_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= 8'd0;
      sel_q    <= 2'd0;
      shadow_q <= 4'd0;
      y_q      <= 4'd0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      wv_q     <= wv_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.Y          = y_q;
  assign bus.word_valid = wv_q;
  assign bus.busy       = (state_q == CAPTURE);

endmodule
